mult_count_ctrl: RTL

Run controller for the counter/multiplier datapath. It clears the two 8-bit operand counters, then steps them with count-enable pulses for N operand pairs. It tracks the multiplier's pipeline latency, captures each 16-bit product and keeps a running sum. Start, busy and done handshakes go to the enclosing system logic. It sits beside the multiplier in the system wrapper and drives the counter CE and clear pins that the bench currently ties off.

---
 rtl/mult_count_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mult_count_ctrl.sv
// Run controller for the counter/multiplier datapath: clears and steps the operand
// counters for N pairs, tracks multiplier latency, captures products and accumulates them.
module mult_count_ctrl #(
    parameter int MULT_LAT = 3,
    parameter int RATIO    = 2
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        START,
    input  logic [7:0]  COUNT,
    input  logic        ABORT,
    input  logic [15:0] P,
    output logic        SCLR,
    output logic        CE_1,
    output logic        CE_2,
    output logic [15:0] PROD,
    output logic        PROD_VALID,
    output logic [23:0] ACC,
    output logic        BUSY,
    output logic        DONE,
    output logic [2:0]  STATE_DBG
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } state_e;

    localparam int                  RW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [RW-1:0]       R_LAST   = RW'(RATIO - 1);
    localparam logic [MULT_LAT-1:0] PIPE_MSB = MULT_LAT'(1) << (MULT_LAT - 1);

    state_e              state_q, state_d;
    logic [7:0]          n_q, n_d;
    logic [7:0]          k_q, k_d;
    logic [RW-1:0]       r_q, r_d;
    logic [MULT_LAT-1:0] pipe_q, pipe_d;
    logic [15:0]         prod_q, prod_d;
    logic                pv_q, pv_d;
    logic [23:0]         acc_q, acc_d;
    logic                sclr_q, sclr_d;
    logic                ce1_q, ce1_d;
    logic                ce2_q, ce2_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                capture;
    logic [RW-1:0]       r_inc;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        r_d     = r_q;
        pipe_d  = pipe_q << 1;
        prod_d  = prod_q;
        pv_d    = 1'b0;
        acc_d   = acc_q;
        sclr_d  = 1'b0;
        ce1_d   = 1'b0;
        ce2_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        r_inc   = (r_q == R_LAST) ? '0 : r_q + RW'(1);

        // The pipe is only non-empty while busy, so ABORT alone gates discarding.
        capture = pipe_q[MULT_LAT-1] && !ABORT;
        if (capture) begin
            prod_d = P;
            acc_d  = acc_q + {8'd0, P};
            pv_d   = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (COUNT != 8'd0) begin
                        n_d     = COUNT;
                        state_d = S_CLEAR;
                        sclr_d  = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                pipe_d = '0;
                if (ABORT) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = '0;
                    k_d     = 8'd0;
                    r_d     = '0;
                    state_d = S_ISSUE;
                    ce1_d   = 1'b1;
                    ce2_d   = (R_LAST == '0);
                    busy_d  = 1'b1;
                end
            end
            S_ISSUE: begin
                if (ABORT) begin
                    pipe_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    pipe_d = (pipe_q << 1) | MULT_LAT'(1);
                    k_d    = k_q + 8'd1;
                    r_d    = r_inc;
                    busy_d = 1'b1;
                    if (k_q == n_q - 8'd1) begin
                        state_d = S_DRAIN;
                    end else begin
                        ce1_d = 1'b1;
                        ce2_d = (r_inc == R_LAST);
                    end
                end
            end
            S_DRAIN: begin
                if (ABORT) begin
                    pipe_d  = '0;
                    state_d = S_IDLE;
                end else if (pipe_q == PIPE_MSB) begin
                    // Final valid is being captured now; DONE lines up with its PROD_VALID.
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            n_q     <= 8'd0;
            k_q     <= 8'd0;
            r_q     <= '0;
            pipe_q  <= '0;
            prod_q  <= 16'd0;
            pv_q    <= 1'b0;
            acc_q   <= 24'd0;
            sclr_q  <= 1'b0;
            ce1_q   <= 1'b0;
            ce2_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            r_q     <= r_d;
            pipe_q  <= pipe_d;
            prod_q  <= prod_d;
            pv_q    <= pv_d;
            acc_q   <= acc_d;
            sclr_q  <= sclr_d;
            ce1_q   <= ce1_d;
            ce2_q   <= ce2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SCLR       = sclr_q;
    assign CE_1       = ce1_q;
    assign CE_2       = ce2_q;
    assign PROD       = prod_q;
    assign PROD_VALID = pv_q;
    assign ACC        = acc_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign STATE_DBG  = state_q;

endmodule
